pool_apb_ctrl: RTL and testbench
================================

# pool_apb_ctrl

APB initiator that drives the pooling block's APB register file on behalf of an on-chip sequencer. Per command it programs the configuration register, pulses start, polls the status register until done, reads the cycle counter, and clears start. It then returns the counter value and an error summary on a valid/ready response port. It removes the need for CPU-driven APB sequencing when pooling layers are chained in hardware.

## Interface
Parameters:
- CTRL_ADDR, 32'h0000_0000: start/control register; bit0 = start
- STATUS_ADDR, 32'h0000_0004: status register; bit0 = done
- CNT_ADDR, 32'h0000_0008: clock counter register
- CFG_ADDR, 32'h0000_000C: pooling configuration register
- POLL_GAP, 4: idle cycles between consecutive status polls (≥0)
- MAX_POLLS, 1024: poll limit; used only when the timeout is compiled in

Ports:
- CLK  in  1  clock; all logic is on the rising edge
- RESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_cfg  in  32  value written to CFG_ADDR; sampled on accept
- rsp_valid  out  1  response available; held until rsp_ready
- rsp_ready  in  1  response consumer ready
- rsp_cycles  out  32  CNT_ADDR read data; 0 if that read was skipped
- rsp_err  out  1  any transfer completed with PSLVERR=1
- rsp_timeout  out  1  poll limit hit; constant 0 without the macro
- busy  out  1  high in every state except IDLE
- PADDR  out  32;  PSEL  out  1;  PENABLE  out  1;  PWRITE  out  1;  PWDATA  out  32
- PRDATA  in  32;  PREADY  in  1;  PSLVERR  in  1

## Operation
- Reset values: all outputs 0, except cmd_ready=1. State is IDLE and all internal registers are cleared.
- Transfer steps, in order:
  - S0: write CFG_ADDR with cmd_cfg
  - S1: write CTRL_ADDR with 1
  - S2: read STATUS_ADDR (repeated while polling)
  - S3: read CNT_ADDR
  - S4: write CTRL_ADDR with 0
- States: IDLE, SETUP, ACCESS, GAP, RESP.
- IDLE → SETUP on cmd_valid&&cmd_ready. The command is latched and the step is set to S0.
- SETUP: PSEL=1, PENABLE=0. PADDR, PWRITE and PWDATA take the step's values; PWDATA=0 on reads. Always goes to ACCESS next cycle.
- ACCESS: PSEL=1, PENABLE=1. Address, control and data are held stable. The state stays in ACCESS while PREADY=0. On PREADY=1 the transfer completes:
  - PSLVERR=1 on any step other than S4: set err, jump to S4.
  - PSLVERR=1 on S4: set err.
  - S2 with PRDATA[0]=0: go to GAP, or directly to SETUP if POLL_GAP=0.
  - S2 with PRDATA[0]=1: go to S3.
  - S3: capture PRDATA into rsp_cycles.
  - Otherwise advance to the next step.
  - After S4 completes, go to RESP.
- GAP: PSEL=0 for POLL_GAP cycles, then SETUP of S2.
- RESP: rsp_valid=1 with stable rsp_* outputs. On rsp_ready the state returns to IDLE and rsp_valid drops the next cycle.
- PSEL and PENABLE are 0 in IDLE, GAP and RESP.
- rsp_* fields are cleared on command accept.
- The clear write S4 is always issued once S0 has started, so the pooling block never stays in the started condition.

## Timing
- Accept at edge T → SETUP of S0 at cycle T+1.
- Each transfer takes 2 cycles plus PREADY wait states.
- Best case (PREADY=1 throughout, done on the first poll): 5 transfers; rsp_valid is high in cycle T+11.
- Each extra poll adds 2+POLL_GAP cycles.
- Next command can be accepted the cycle after the rsp_valid&&rsp_ready edge, since cmd_ready is high in IDLE.
- cmd_valid while busy: ignored, not queued.
- RESET asserted mid-transfer: PSEL and PENABLE drop immediately (asynchronous). The in-flight APB transfer is abandoned and no response is produced. The downstream slave shares the same reset.

## Configuration
- POOL_APB_CTRL_TIMEOUT_EN defined:
  - A 32-bit poll counter (cleared on accept) counts S2 reads that return done=0.
  - When it reaches MAX_POLLS: set rsp_timeout=1, rsp_cycles=0, skip S3, issue S4, then RESP.
- POOL_APB_CTRL_TIMEOUT_EN undefined:
  - Polling is unbounded.
  - rsp_timeout is tied to 0 and no poll counter is synthesized.

## Test plan
- cmd_cfg=32'h0000_0E0E; slave has PREADY=1, done on 1st poll, counter=1234. Required: APB writes 0x0C←0x0E0E, 0x00←1; reads 0x04, 0x08; write 0x00←0. rsp_valid at T+11, rsp_cycles=1234, rsp_err=0.
- Done on 3rd poll, POLL_GAP=4. Required: three S2 reads with PSEL low for 4 cycles between them; rsp_valid at T+23.
- PREADY low for 3 cycles on every ACCESS. Required: PADDR, PWDATA and PWRITE stable throughout each wait; response timing is 15 cycles later than the zero-wait case.
- PSLVERR=1 on the S1 write. Required: next transfer is S4 (write 0x00←0); rsp_err=1, rsp_cycles=0.
- With POOL_APB_CTRL_TIMEOUT_EN defined and MAX_POLLS=8, done never set. Required: exactly 8 status reads, then S4; rsp_timeout=1, rsp_cycles=0.
- RESET pulsed during the ACCESS of S3, rsp_ready held 0 on a later command. Required:
  - On reset: PSEL=0 and busy=0 immediately; cmd_ready=1.
  - On the new command: rsp_valid is held until rsp_ready, and cmd_valid during busy is ignored.

Source files
------------

// File: rtl/pool_apb_ctrl.sv
// APB initiator that sequences one pooling-block run per command.
// Optional poll timeout: define POOL_APB_CTRL_TIMEOUT_EN.
module pool_apb_ctrl #(
    parameter logic [31:0] CTRL_ADDR   = 32'h0000_0000,
    parameter logic [31:0] STATUS_ADDR = 32'h0000_0004,
    parameter logic [31:0] CNT_ADDR    = 32'h0000_0008,
    parameter logic [31:0] CFG_ADDR    = 32'h0000_000C,
    parameter int unsigned POLL_GAP    = 4,
    parameter int unsigned MAX_POLLS   = 1024
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_cfg,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_cycles,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [31:0] PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, GAP, RESP} state_e;
    typedef enum logic [2:0] {S0, S1, S2, S3, S4} step_e;

    localparam logic [31:0] GAP_LAST = 32'(POLL_GAP - 1);

    state_e      state_q, state_d;
    step_e       step_q, step_d;
    logic [31:0] cfg_q, cfg_d;
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] gap_q, gap_d;
    logic        err_q, err_d;
    logic        poll_limit;

`ifdef POOL_APB_CTRL_TIMEOUT_EN
    logic [31:0] polls_q, polls_d;
    logic        timeout_q, timeout_d;

    // Limit is reached by the read that is about to be counted.
    assign poll_limit  = (polls_q + 32'd1) == 32'(MAX_POLLS);
    assign rsp_timeout = timeout_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            polls_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            polls_q   <= polls_d;
            timeout_q <= timeout_d;
        end
    end
`else
    logic unused_max_polls;

    assign unused_max_polls = ^MAX_POLLS;
    assign poll_limit       = 1'b0;
    assign rsp_timeout      = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            step_q   <= S0;
            cfg_q    <= '0;
            cycles_q <= '0;
            gap_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            cfg_q    <= cfg_d;
            cycles_q <= cycles_d;
            gap_q    <= gap_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        cfg_d    = cfg_q;
        cycles_d = cycles_q;
        gap_d    = gap_q;
        err_d    = err_q;
`ifdef POOL_APB_CTRL_TIMEOUT_EN
        polls_d   = polls_q;
        timeout_d = timeout_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d  = SETUP;
                    step_d   = S0;
                    cfg_d    = cmd_cfg;
                    cycles_d = '0;
                    gap_d    = '0;
                    err_d    = 1'b0;
`ifdef POOL_APB_CTRL_TIMEOUT_EN
                    polls_d   = '0;
                    timeout_d = 1'b0;
`endif
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    state_d = SETUP;
                    // An error anywhere still ends with the start-clear write.
                    if (PSLVERR) begin
                        err_d = 1'b1;
                        if (step_q == S4) state_d = RESP;
                        else step_d = S4;
                    end else begin
                        case (step_q)
                            S0: step_d = S1;
                            S1: step_d = S2;
                            S2: begin
                                if (PRDATA[0]) begin
                                    step_d = S3;
                                end else begin
`ifdef POOL_APB_CTRL_TIMEOUT_EN
                                    polls_d = polls_q + 32'd1;
                                    if (poll_limit) timeout_d = 1'b1;
`endif
                                    if (poll_limit) begin
                                        step_d = S4;
                                    end else if (POLL_GAP != 0) begin
                                        state_d = GAP;
                                        gap_d   = '0;
                                    end
                                end
                            end
                            S3: begin
                                cycles_d = PRDATA;
                                step_d   = S4;
                            end
                            default: state_d = RESP;
                        endcase
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) state_d = SETUP;
                else gap_d = gap_q + 32'd1;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic psel;

    assign psel    = (state_q == SETUP) || (state_q == ACCESS);
    assign PSEL    = psel;
    assign PENABLE = (state_q == ACCESS);

    always_comb begin
        PADDR  = '0;
        PWRITE = 1'b0;
        PWDATA = '0;
        if (psel) begin
            case (step_q)
                S0: begin
                    PADDR  = CFG_ADDR;
                    PWRITE = 1'b1;
                    PWDATA = cfg_q;
                end
                S1: begin
                    PADDR  = CTRL_ADDR;
                    PWRITE = 1'b1;
                    PWDATA = 32'd1;
                end
                S2: PADDR = STATUS_ADDR;
                S3: PADDR = CNT_ADDR;
                default: begin
                    PADDR  = CTRL_ADDR;
                    PWRITE = 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_cycles = cycles_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_pool_apb_ctrl.sv
// Scoreboard bench for pool_apb_ctrl with a behavioural APB slave.
// Timeout case runs only when POOL_APB_CTRL_TIMEOUT_EN is defined.
module tb_pool_apb_ctrl;

    localparam logic [31:0] A_CTRL = 32'h0;
    localparam logic [31:0] A_STAT = 32'h4;
    localparam logic [31:0] A_CNT  = 32'h8;
    localparam logic [31:0] A_CFG  = 32'hC;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } apb_exp_t;

    typedef struct {
        logic [31:0] cycles;
        logic        err;
        logic        to;
        int          acc;
        int          lat;
        int          hold;
    } rsp_exp_t;

    logic        CLK = 0, RESET = 1;
    logic        cmd_valid = 0, cmd_ready;
    logic [31:0] cmd_cfg = 0;
    logic        rsp_valid, rsp_ready = 0;
    logic [31:0] rsp_cycles;
    logic        rsp_err, rsp_timeout, busy;
    logic [31:0] PADDR, PWDATA;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PRDATA = 0;
    logic        PREADY = 0, PSLVERR = 0;

    pool_apb_ctrl #(.POLL_GAP(4), .MAX_POLLS(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_cfg(cmd_cfg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_cycles(rsp_cycles), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0;
    int cyc = 0;
    int rsp_done = 0, rsp_expected = 0;
    apb_exp_t apb_q[$];
    rsp_exp_t rsp_q[$];

    // slave behaviour for the current command
    int          s_done_on = 1, s_waits = 0, s_err_en = 0;
    logic [31:0] s_cnt = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // APB slave + transfer scoreboard
    int          wcnt = 0, polls = 0, idle_run = 0;
    logic [31:0] last_addr = '1, l_addr = 0, l_data = 0;
    logic        l_wr = 0;

    always @(negedge CLK) begin
        if (RESET) begin
            PREADY = 0; PSLVERR = 0; wcnt = 0; idle_run = 0; last_addr = '1;
        end else if (!PSEL) begin
            PREADY = 0; PSLVERR = 0;
            idle_run++;
        end else if (!PENABLE) begin
            PREADY = 0; PSLVERR = 0;
            if (PADDR == A_STAT && last_addr == A_STAT)
                chk("poll_gap", idle_run, 4);
            idle_run = 0;
            l_addr = PADDR; l_wr = PWRITE; l_data = PWDATA;
        end else begin
            chk("hold_paddr", PADDR, l_addr);
            chk("hold_pwrite", PWRITE, l_wr);
            chk("hold_pwdata", PWDATA, l_data);
            if (wcnt < s_waits) begin
                wcnt++; PREADY = 0; PSLVERR = 0;
            end else begin
                apb_exp_t e;
                wcnt = 0; PREADY = 1;
                PSLVERR = (s_err_en != 0) && PWRITE && PADDR == A_CTRL
                          && PWDATA == 32'd1;
                PRDATA = 0;
                if (PWRITE && PADDR == A_CFG) polls = 0;
                if (!PWRITE && PADDR == A_STAT) begin
                    polls++;
                    PRDATA = {31'd0, s_done_on != 0 && polls >= s_done_on};
                end
                if (!PWRITE && PADDR == A_CNT) PRDATA = s_cnt;
                if (apb_q.size() == 0) begin
                    chk("apb_unexpected_addr", PADDR, 32'hFFFF_FFFF);
                end else begin
                    e = apb_q.pop_front();
                    chk("apb_addr", PADDR, e.addr);
                    chk("apb_pwrite", PWRITE, e.wr);
                    chk("apb_pwdata", PWDATA, e.data);
                end
                last_addr = PADDR;
            end
        end
    end

    // response monitor
    int          hcnt = 0, vlen = 0;
    logic        in_rsp = 0;
    rsp_exp_t    cur;
    logic [31:0] sv_cycles = 0;
    logic        sv_err = 0, sv_to = 0;

    always @(negedge CLK) begin
        if (RESET) begin
            in_rsp = 0; rsp_ready = 0;
        end else if (rsp_valid) begin
            if (!in_rsp) begin
                in_rsp = 1; vlen = 0;
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", rsp_cycles, 32'hFFFF_FFFF);
                    cur = '{0, 0, 0, cyc, 0, 0};
                end else begin
                    cur = rsp_q.pop_front();
                    chk("rsp_cycles", rsp_cycles, cur.cycles);
                    chk("rsp_err", rsp_err, cur.err);
                    chk("rsp_timeout", rsp_timeout, cur.to);
                    chk("rsp_latency", cyc - cur.acc, cur.lat);
                end
                sv_cycles = rsp_cycles; sv_err = rsp_err; sv_to = rsp_timeout;
                hcnt = cur.hold;
            end else begin
                chk("rsp_stable_cycles", rsp_cycles, sv_cycles);
                chk("rsp_stable_err", {rsp_err, rsp_timeout}, {sv_err, sv_to});
            end
            vlen++;
            if (hcnt > 0) begin
                rsp_ready = 0; hcnt--;
            end else begin
                rsp_ready = 1;
            end
        end else begin
            if (in_rsp) begin
                chk("rsp_valid_len", vlen, cur.hold + 1);
                rsp_done++;
            end
            in_rsp = 0; rsp_ready = 0;
        end
    end

    task automatic push_apb(input logic [31:0] a, input logic w,
                            input logic [31:0] d);
        apb_exp_t e;
        e.addr = a; e.wr = w; e.data = d;
        apb_q.push_back(e);
    endtask

    // Issue one command; lat is edges from accept to first rsp_valid sample.
    task automatic issue(input logic [31:0] cfg, input int done_on,
                         input logic [31:0] cnt, input int waits,
                         input int err_s1, input int n_polls, input int s3,
                         input int abort, input logic [31:0] e_cyc,
                         input logic e_err, input logic e_to,
                         input int lat, input int hold);
        int ok = 0;
        s_done_on = done_on; s_cnt = cnt; s_waits = waits; s_err_en = err_s1;
        @(negedge CLK);
        cmd_cfg = cfg; cmd_valid = 1;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready) begin ok = 1; break; end
            @(negedge CLK);
        end
        if (ok == 0) begin
            checks++; errors++;
            $display("FAIL cmd_accept: cmd_ready never high");
        end else begin
            rsp_exp_t r;
            push_apb(A_CFG, 1, cfg);
            push_apb(A_CTRL, 1, 32'd1);
            for (int p = 0; p < n_polls; p++) push_apb(A_STAT, 0, 0);
            if (s3 != 0) push_apb(A_CNT, 0, 0);
            if (abort == 0) begin
                push_apb(A_CTRL, 1, 0);
                r.cycles = e_cyc; r.err = e_err; r.to = e_to;
                r.acc = cyc + 1; r.lat = lat; r.hold = hold;
                rsp_q.push_back(r);
                rsp_expected++;
            end
        end
        @(negedge CLK);
        cmd_valid = 0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (rsp_done < rsp_expected && n < 3000) begin
            @(negedge CLK); n++;
        end
        if (rsp_done < rsp_expected) begin
            checks++; errors++;
            $display("FAIL rsp_wait: got %0d responses expected %0d",
                     rsp_done, rsp_expected);
        end
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_psel", {PSEL, PENABLE}, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_cycles", rsp_cycles, 0);
        chk("reset_paddr", PADDR, 0);
        RESET = 0;
        @(negedge CLK);

        // best case: 5 transfers, response 10 edges after accept
        issue(32'h0000_0E0E, 1, 32'd1234, 0, 0, 1, 1, 0,
              32'd1234, 0, 0, 10, 0);
        wait_rsp();
        // done on third poll: two extra polls of 2+4 cycles
        issue(32'h0000_0A0A, 3, 32'd500, 0, 0, 3, 1, 0,
              32'd500, 0, 0, 22, 0);
        wait_rsp();
        // three wait states on every access
        issue(32'h0000_0303, 1, 32'hCAFE, 3, 0, 1, 1, 0,
              32'hCAFE, 0, 0, 25, 0);
        wait_rsp();
        // slave error on the start write jumps straight to the clear write
        issue(32'h0000_0707, 1, 32'd42, 0, 1, 0, 0, 0,
              32'd0, 1, 0, 6, 0);
        wait_rsp();
`ifdef POOL_APB_CTRL_TIMEOUT_EN
        // never done: 8 polls, 7 gaps, then clear write
        issue(32'h0000_0011, 0, 32'd5, 0, 0, 8, 0, 0,
              32'd0, 0, 1, 50, 0);
        wait_rsp();
`endif
        // reset during the counter read
        begin
            int hit = 0;
            issue(32'h0000_0909, 1, 32'd321, 2, 0, 1, 1, 1,
                  32'd0, 0, 0, 0, 0);
            for (int i = 0; i < 200; i++) begin
                if (PSEL && PENABLE && PADDR == A_CNT) begin hit = 1; break; end
                @(negedge CLK);
            end
            if (hit == 0) begin
                checks++; errors++;
                $display("FAIL reset_window: counter read never seen");
            end
            #1 RESET = 1;
            #1;
            chk("midreset_psel", {PSEL, PENABLE}, 0);
            chk("midreset_busy", busy, 0);
            chk("midreset_cmd_ready", cmd_ready, 1);
            chk("midreset_rsp_valid", rsp_valid, 0);
            apb_q.delete();
            repeat (2) @(negedge CLK);
            RESET = 0;
            @(negedge CLK);
        end
        // held response and ignored command while busy
        fork
            begin
                issue(32'h0000_1234, 2, 32'd77, 0, 0, 2, 1, 0,
                      32'd77, 0, 0, 16, 5);
                wait_rsp();
            end
            begin
                repeat (4) @(negedge CLK);
                for (int i = 0; i < 4; i++) begin
                    cmd_cfg = 32'hDEAD_BEEF; cmd_valid = 1;
                    chk("busy_cmd_ready", cmd_ready, 0);
                    @(negedge CLK);
                end
                cmd_valid = 0;
            end
        join
        repeat (20) @(negedge CLK);
        chk("idle_after_all", busy, 0);
        chk("apb_q_left", apb_q.size(), 0);
        chk("rsp_q_left", rsp_q.size(), 0);
        chk("rsp_count", rsp_done, rsp_expected);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
